// File: rtl/vedic_arith_pkg.sv
// vedic_arith_pkg: constants and types shared by the vedic multiplier and the restoring divider.
package vedic_arith_pkg;
    localparam int VEDIC_WIDTH = 16;
    localparam logic [31:0] DIV_ZERO_Q = '1;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} div_state_t;
endpackage

// File: rtl/div_restore_step.sv
// div_restore_step: one combinational restoring-division step on a WIDTH+1 bit trial subtraction.
module div_restore_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);
    logic [WIDTH:0] shifted, diff;
    assign shifted = {rem_in, bit_in};
    assign diff    = shifted - {1'b0, divisor};
    // no borrow out of the extra bit means shifted >= divisor
    assign q_bit   = ~diff[WIDTH];
    assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: unsigned restoring divider, one quotient bit per clock, valid/ready on both sides.
module seq_restoring_divider
    import vedic_arith_pkg::*;
#(
    parameter int WIDTH = VEDIC_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    div_state_t       state;
    logic [WIDTH-1:0] q_r, r_r, d_r, step_rem;
    logic [CNT_W-1:0] cnt;
    logic             step_bit, last;
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign last      = cnt == CNT_W'(WIDTH - 1);
    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem_in (r_r),
        .bit_in (q_r[WIDTH-1]),
        .divisor(d_r),
        .rem_out(step_rem),
        .q_bit  (step_bit)
    );
    // q_r starts as the dividend and is shifted out MSB-first while quotient bits shift in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            q_r         <= '0;
            r_r         <= '0;
            d_r         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    q_r         <= dividend;
                    d_r         <= divisor;
                    r_r         <= '0;
                    cnt         <= '0;
                    div_by_zero <= divisor == '0;
                    if (divisor == '0) begin
                        quotient  <= DIV_ZERO_Q[WIDTH-1:0];
                        remainder <= dividend;
                        state     <= DONE;
                    end else begin
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    q_r <= {q_r[WIDTH-2:0], step_bit};
                    r_r <= step_rem;
                    cnt <= cnt + CNT_W'(1);
                    if (last) begin
                        quotient  <= {q_r[WIDTH-2:0], step_bit};
                        remainder <= step_rem;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: directed and randomized checks against an arithmetic reference model.
module tb_seq_restoring_divider;
    localparam int W = 16;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         in_ready, out_valid, div_by_zero;
    logic [W-1:0] quotient, remainder;
    int           checks = 0;
    int           errors = 0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!in_ready && t < 100) begin
            step();
            t++;
        end
        check("ready_timeout", 64'(in_ready), 64'd1);
    endtask

    task automatic run_op(input logic [W-1:0] n, input logic [W-1:0] d, input int stall);
        int           lat;
        logic         edz;
        logic [W-1:0] eq, er;
        edz = d == '0;
        eq  = edz ? '1 : W'(int'(n) / int'(d));
        er  = edz ? n : W'(int'(n) % int'(d));
        wait_ready();
        in_valid = 1'b1;
        dividend = n;
        divisor  = d;
        step();
        lat = 0;
        while (!out_valid && lat < 4 * W) begin
            in_valid = 1'($urandom);
            dividend = W'($urandom);
            divisor  = W'($urandom);
            step();
            lat++;
        end
        check("latency", 64'(lat), edz ? 64'd0 : 64'(W));
        check("quotient", 64'(quotient), 64'(eq));
        check("remainder", 64'(remainder), 64'(er));
        check("div_by_zero", 64'(div_by_zero), 64'(edz));
        if (!edz) begin
            check("identity", 64'(quotient) * 64'(d) + 64'(remainder), 64'(n));
            check("rem_lt_div", 64'(remainder < d), 64'd1);
        end
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            dividend = W'($urandom);
            divisor  = W'($urandom);
            step();
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_ready", 64'(in_ready), 64'd0);
            check("hold_q", 64'(quotient), 64'(eq));
            check("hold_r", 64'(remainder), 64'(er));
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("valid_drop", 64'(out_valid), 64'd0);
        check("ready_back", 64'(in_ready), 64'd1);
        check("q_kept", 64'(quotient), 64'(eq));
        check("r_kept", 64'(remainder), 64'(er));
    endtask

    initial begin
        logic [W-1:0] n, d;
        logic         seen;
        #1;
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_q", 64'(quotient), 64'd0);
        check("rst_r", 64'(remainder), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        run_op(100, 7, 0);
        run_op(16'hFFFF, 1, 0);
        run_op(3, 10, 0);
        run_op(5, 0, 0);
        run_op(9, 3, 0);
        run_op(1000, 33, 5);
        run_op(16'hFFFF, 16'hFFFF, 0);
        run_op(77, 77, 1);
        wait_ready();
        in_valid = 1'b1;
        dividend = 50000;
        divisor  = 123;
        step();
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_ready", 64'(in_ready), 64'd1);
        check("arst_q", 64'(quotient), 64'd0);
        check("arst_r", 64'(remainder), 64'd0);
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (24) begin
            step();
            seen |= out_valid;
        end
        check("no_result_after_rst", 64'(seen), 64'd0);
        run_op(50000, 123, 0);
        for (int k = 0; k < 2000; k++) begin
            case ($urandom_range(0, 5))
                0: n = '0;
                1: n = 16'hFFFF;
                default: n = W'($urandom);
            endcase
            case ($urandom_range(0, 6))
                0: d = '0;
                1: d = 1;
                2: d = 16'hFFFF;
                3: d = W'($urandom_range(2, 255));
                default: d = W'($urandom);
            endcase
            run_op(n, d, $urandom_range(0, 2));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
